// File: rtl/adc_align.sv
// adc_align: frame/lane alignment engine for deserialised ADC data.
// Trains the frame word with coherent bitslips, trims single lanes against
// a test pattern while locked, and keeps saturating instability counters.
module adc_align #(
    parameter int              NLANES = 8,
    parameter int              SERW   = 6,
    parameter logic [SERW-1:0] FRPAT  = 6'b111000,
    parameter int              SETTLE = 3,
    parameter int              LOCKN  = 16,
    parameter int              LOSEN  = 4,
    parameter int              CNTW   = 8
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [SERW-1:0]            FR,
    input  logic [NLANES*SERW-1:0]     DATA,
    input  logic                       TRAIN_EN,
    input  logic                       IND_EN,
    input  logic [SERW-1:0]            LANE_PAT,
    input  logic                       CHK_EN,
    input  logic                       CHK_CLR,
    output logic                       BS_FR,
    output logic [NLANES-1:0]          BS,
    output logic                       LOCKED,
    output logic                       FAIL,
    output logic [2:0]                 STATE,
    output logic [NLANES-1:0]          LANE_OK,
    output logic [NLANES:0]            SLIP_STICKY,
    output logic [(NLANES+1)*CNTW-1:0] INS_CNT
);

    localparam int SLW = $clog2(SERW + 2);
    localparam int MTW = $clog2(LOCKN + 1);
    localparam int MSW = $clog2(LOSEN + 1);
    localparam int WTW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_HUNT = 3'd1, S_SLIP = 3'd2, S_WAIT = 3'd3,
        S_VERIFY = 3'd4, S_LOCK = 3'd5, S_FAIL = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        L_CHK = 3'd0, L_SLIP = 3'd1, L_WAIT = 3'd2, L_DONE = 3'd3, L_BAD = 3'd4
    } lstate_t;

    state_t           state_q, state_d;
    logic [SLW-1:0]   slip_q, slip_d;
    logic [WTW-1:0]   wait_q, wait_d;
    logic [MTW-1:0]   match_q, match_d;
    logic [MSW-1:0]   miss_q, miss_d;
    logic             bs_fr_q;
    logic             fr_match;

    lstate_t          lst_q [NLANES];
    lstate_t          lst_d [NLANES];
    logic [MTW-1:0]   lmatch_q [NLANES];
    logic [MTW-1:0]   lmatch_d [NLANES];
    logic [SLW-1:0]   lslip_q [NLANES];
    logic [SLW-1:0]   lslip_d [NLANES];
    logic [WTW-1:0]   lwait_q [NLANES];
    logic [WTW-1:0]   lwait_d [NLANES];
    logic [NLANES-1:0] lbs_q, lbs_d;
    logic             lane_act;

    logic [SERW-1:0]  lane_word [NLANES];
    logic [SERW-1:0]  prev_lane_q [NLANES];
    logic [SERW-1:0]  prev_fr_q;
    logic [NLANES:0]  chg;
    logic [CNTW-1:0]  cnt_q [NLANES+1];
    logic [NLANES:0]  sticky_q;
    logic [NLANES-1:0] bs_all;

    // Split the packed lane bus and flag which words changed since last cycle.
    always_comb begin
        chg = '0;
        chg[0] = (FR != prev_fr_q);
        for (int i = 0; i < NLANES; i++) begin
            lane_word[i] = DATA[SERW*i +: SERW];
            chg[i+1]     = (lane_word[i] != prev_lane_q[i]);
        end
    end

    assign fr_match = (FR == FRPAT);
    // Lanes are trimmed only while the frame is locked and trimming is enabled.
    assign lane_act = TRAIN_EN && IND_EN && (state_q == S_LOCK);

    // Main training FSM: next state and counter updates.
    always_comb begin
        state_d = state_q;
        slip_d  = slip_q;
        wait_d  = wait_q;
        match_d = match_q;
        miss_d  = miss_q;
        if (!TRAIN_EN) begin
            state_d = S_IDLE;
            slip_d  = '0;
            wait_d  = '0;
            match_d = '0;
            miss_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_HUNT;
                    slip_d  = '0;
                end
                S_HUNT: begin
                    if (fr_match) begin
                        state_d = S_VERIFY;
                        match_d = MTW'(1);
                    end else if (slip_q >= SLW'(SERW)) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_SLIP;
                    end
                end
                S_SLIP: begin
                    if (slip_q != '1) slip_d = slip_q + SLW'(1);
                    wait_d  = WTW'(SETTLE);
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    wait_d = wait_q - WTW'(1);
                    if (wait_q <= WTW'(1)) state_d = S_HUNT;
                end
                S_VERIFY: begin
                    if (!fr_match) begin
                        state_d = S_SLIP;
                    end else if (match_q == MTW'(LOCKN - 1)) begin
                        state_d = S_LOCK;
                        miss_d  = '0;
                    end else begin
                        match_d = match_q + MTW'(1);
                    end
                end
                S_LOCK: begin
                    if (fr_match) begin
                        miss_d = '0;
                    end else if (miss_q == MSW'(LOSEN - 1)) begin
                        state_d = S_HUNT;
                        slip_d  = '0;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_q + MSW'(1);
                    end
                end
                S_FAIL:  state_d = S_FAIL;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Main FSM registers; the frame pulse is registered from the SLIP decision.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            slip_q  <= '0;
            wait_q  <= '0;
            match_q <= '0;
            miss_q  <= '0;
            bs_fr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slip_q  <= slip_d;
            wait_q  <= wait_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            bs_fr_q <= (state_d == S_SLIP);
        end
    end

    // Per-lane trim FSMs; all held in L_CHK with cleared counters when inactive.
    always_comb begin
        lbs_d = '0;
        for (int i = 0; i < NLANES; i++) begin
            lst_d[i]    = lst_q[i];
            lmatch_d[i] = lmatch_q[i];
            lslip_d[i]  = lslip_q[i];
            lwait_d[i]  = lwait_q[i];
            if (!lane_act) begin
                lst_d[i]    = L_CHK;
                lmatch_d[i] = '0;
                lslip_d[i]  = '0;
                lwait_d[i]  = '0;
            end else begin
                case (lst_q[i])
                    L_CHK: begin
                        if (lane_word[i] == LANE_PAT) begin
                            if (lmatch_q[i] == MTW'(LOCKN - 1)) lst_d[i] = L_DONE;
                            else lmatch_d[i] = lmatch_q[i] + MTW'(1);
                        end else begin
                            lmatch_d[i] = '0;
                            if (lslip_q[i] >= SLW'(SERW)) lst_d[i] = L_BAD;
                            else lst_d[i] = L_SLIP;
                        end
                    end
                    L_SLIP: begin
                        if (lslip_q[i] != '1) lslip_d[i] = lslip_q[i] + SLW'(1);
                        lwait_d[i] = WTW'(SETTLE);
                        lst_d[i]   = L_WAIT;
                    end
                    L_WAIT: begin
                        lwait_d[i] = lwait_q[i] - WTW'(1);
                        if (lwait_q[i] <= WTW'(1)) begin
                            lst_d[i]    = L_CHK;
                            lmatch_d[i] = '0;
                        end
                    end
                    L_DONE:  lst_d[i] = L_DONE;
                    L_BAD:   lst_d[i] = L_BAD;
                    default: lst_d[i] = L_CHK;
                endcase
            end
            lbs_d[i] = (lst_d[i] == L_SLIP);
        end
    end

    // Lane FSM registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lbs_q <= '0;
            for (int i = 0; i < NLANES; i++) begin
                lst_q[i]    <= L_CHK;
                lmatch_q[i] <= '0;
                lslip_q[i]  <= '0;
                lwait_q[i]  <= '0;
            end
        end else begin
            lbs_q <= lbs_d;
            for (int i = 0; i < NLANES; i++) begin
                lst_q[i]    <= lst_d[i];
                lmatch_q[i] <= lmatch_d[i];
                lslip_q[i]  <= lslip_d[i];
                lwait_q[i]  <= lwait_d[i];
            end
        end
    end

    assign bs_all = {NLANES{bs_fr_q}} | lbs_q;

    // Previous-word history, saturating instability counters and sticky slip flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prev_fr_q <= '0;
            sticky_q  <= '0;
            for (int i = 0; i < NLANES; i++) prev_lane_q[i] <= '0;
            for (int k = 0; k <= NLANES; k++) cnt_q[k] <= '0;
        end else begin
            prev_fr_q <= FR;
            for (int i = 0; i < NLANES; i++) prev_lane_q[i] <= lane_word[i];
            sticky_q <= CHK_CLR ? '0 : (sticky_q | {bs_fr_q, bs_all});
            for (int k = 0; k <= NLANES; k++) begin
                if (CHK_CLR) cnt_q[k] <= '0;
                else if (CHK_EN && chg[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + CNTW'(1);
            end
        end
    end

    // Output decode and counter packing.
    always_comb begin
        INS_CNT = '0;
        LANE_OK = '0;
        for (int k = 0; k <= NLANES; k++) INS_CNT[CNTW*k +: CNTW] = cnt_q[k];
        for (int i = 0; i < NLANES; i++) LANE_OK[i] = (lst_q[i] == L_DONE);
    end

    assign BS_FR       = bs_fr_q;
    assign BS          = bs_all;
    assign LOCKED      = (state_q == S_LOCK);
    assign FAIL        = (state_q == S_FAIL);
    assign STATE       = state_q;
    assign SLIP_STICKY = sticky_q;

endmodule
